// File: rtl/alu_mul_seq.sv
// Multi-cycle shift-and-add multiplier that borrows the shared 32-bit ALU.
// Produces the low 32 bits of mcand_in * mplier_in using only ALU add and shift-left.
module alu_mul_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] mcand_in,
   input  logic [31:0] mplier_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] product,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_control,
   input  logic [31:0] alu_result,
   output logic [1:0]  state_dbg
);

   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SHL = 4'b0100;

   typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, SHL = 2'd2, DONE = 2'd3} state_t;

   state_t      state;
   logic [31:0] acc;
   logic [31:0] mcand;
   logic [31:0] mplier;
   logic [4:0]  count;

   // busy/done are registered alongside the state so they track it exactly.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         count   <= '0;
         product <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc    <= '0;
                  mcand  <= mcand_in;
                  mplier <= mplier_in;
                  count  <= '0;
                  state  <= ADD;
                  busy   <= 1'b1;
               end
            end
            ADD: begin
               // No multiplier bits left: nothing more can change acc.
               if (mplier == 32'd0) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  if (mplier[0]) acc <= alu_result;
                  state <= SHL;
               end
            end
            SHL: begin
               mcand  <= alu_result;
               mplier <= mplier >> 1;
               count  <= count + 5'd1;
               if (count == 5'd31) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state <= ADD;
               end
            end
            DONE: begin
               product <= acc;
               state   <= IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      alu_a       = '0;
      alu_b       = '0;
      alu_control = 4'b0000;
      case (state)
         ADD: begin
            alu_a       = acc;
            alu_b       = mcand;
            alu_control = ALU_ADD;
         end
         SHL: begin
            alu_a       = mcand;
            alu_b       = 32'd1;
            alu_control = ALU_SHL;
         end
         default: ;
      endcase
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq: latency, product, ALU drive pattern, start
// masking while busy, back-to-back start and mid-run reset.
module tb_alu_mul_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] mcand_in;
   logic [31:0] mplier_in;
   logic        busy;
   logic        done;
   logic [31:0] product;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_control;
   logic [31:0] alu_result;
   logic [1:0]  state_dbg;

   int checks = 0;
   int errors = 0;

   // per-cycle log of the most recent run, indexed by cycle number
   logic [3:0]  ctl_log [0:127];
   logic [31:0] a_log   [0:127];
   logic [31:0] b_log   [0:127];
   int          done_cyc;
   int          busy_cnt;
   int          done_cnt;

   always #5 clk = ~clk;

   alu_mul_seq dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .mcand_in    (mcand_in),
      .mplier_in   (mplier_in),
      .busy        (busy),
      .done        (done),
      .product     (product),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_control (alu_control),
      .alu_result  (alu_result),
      .state_dbg   (state_dbg)
   );

   // Reference ALU: only the two operations the sequencer uses.
   always_comb begin
      alu_result = '0;
      case (alu_control)
         4'b0010: alu_result = alu_a + alu_b;
         4'b0100: alu_result = alu_a << alu_b[4:0];
         default: alu_result = '0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Called at a negedge; start is sampled by the next posedge (edge 0).
   task automatic launch(input logic [31:0] a, input logic [31:0] b);
      mcand_in  = a;
      mplier_in = b;
      start     = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Samples every cycle at the negedge until done, optionally toggling start
   // during cycles 3..5, then checks latency and the product one cycle later.
   task automatic wait_done(input string tag, input int exp_cyc, input logic [31:0] exp_p,
                            input bit noise);
      int cyc;
      cyc      = 0;
      done_cyc = -1;
      busy_cnt = 0;
      while (cyc < 100 && done_cyc < 0) begin
         @(negedge clk);
         cyc++;
         ctl_log[cyc] = alu_control;
         a_log[cyc]   = alu_a;
         b_log[cyc]   = alu_b;
         if (busy) busy_cnt++;
         if (done) done_cyc = cyc;
         if (noise) begin
            start     = (cyc >= 2 && cyc <= 4);
            mcand_in  = 32'd9;
            mplier_in = 32'd9;
         end
      end
      start = 1'b0;
      check({tag, "_done_cycle"}, done_cyc, exp_cyc);
      @(negedge clk);
      check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
      check({tag, "_done_after"}, {31'd0, done}, 32'd0);
      check({tag, "_product"}, product, exp_p);
   endtask

   initial begin
      int nz;
      reset     = 1'b0;
      start     = 1'b0;
      mcand_in  = '0;
      mplier_in = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_product", product, 32'd0);
      check("rst_alu_a", alu_a, 32'd0);
      check("rst_alu_b", alu_b, 32'd0);
      check("rst_alu_control", {28'd0, alu_control}, 32'd0);
      check("rst_state", {30'd0, state_dbg}, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // 6 x 7: ADD/SHL alternate, final ADD sees mplier==0
      launch(32'd6, 32'd7);
      wait_done("m6x7", 8, 32'd42, 1'b0);
      for (int c = 1; c <= 7; c++)
         check($sformatf("m6x7_ctl_c%0d", c), {28'd0, ctl_log[c]},
               (c % 2 == 1) ? 32'h2 : 32'h4);
      check("m6x7_ctl_c8", {28'd0, ctl_log[8]}, 32'h0);
      check("m6x7_add1_b", b_log[1], 32'd6);
      check("m6x7_shl2_a", a_log[2], 32'd6);
      check("m6x7_shl2_b", b_log[2], 32'd1);
      check("m6x7_add3_a", a_log[3], 32'd6);
      check("m6x7_add3_b", b_log[3], 32'd12);
      check("m6x7_add7_a", a_log[7], 32'd42);

      // multiplier 0: early termination
      launch(32'h1234, 32'd0);
      wait_done("mzero", 2, 32'd0, 1'b0);
      check("mzero_busy_cycles", busy_cnt, 32'd2);

      launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("mffff", 65, 32'd1, 1'b0);

      launch(32'd3, 32'h8000_0000);
      wait_done("m3xmsb", 65, 32'h8000_0000, 1'b0);
      nz = 0;
      for (int c = 1; c <= 63; c += 2)
         if (ctl_log[c] != 4'b0010 || a_log[c] != 32'd0) nz++;
      check("m3xmsb_add_acc_zero", nz, 32'd0);

      // start ignored while busy, then accepted in the first IDLE cycle
      launch(32'd6, 32'd7);
      wait_done("mnoise", 8, 32'd42, 1'b1);
      launch(32'd5, 32'd5);
      wait_done("mb2b", 8, 32'd25, 1'b0);

      // reset during cycle 10 aborts the run
      launch(32'hFFFF, 32'hFFFF);
      done_cnt = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      reset = 1'b0;
      @(negedge clk);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_product", product, 32'd0);
      reset = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (done || busy) done_cnt++;
      end
      check("abort_no_activity", done_cnt, 32'd0);
      launch(32'd2, 32'd3);
      wait_done("m2x3", 6, 32'd6, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle multiply sequencer that owns the 32-bit ALU's operand and control inputs and computes a 32×32 product (low 32 bits) by iterated shift-and-add. It uses only existing ALU operations: add (`alucontrol` 4'b0010) and shift-left (4'b0100). The multicycle control unit uses it to implement `mul`. It raises `busy` while it holds the ALU and pulses `done` when the product register is valid.

## Interface
- Parameters: none. Datapath is fixed at 32 bits to match the ALU.
- `clk` in 1: sole clock, rising-edge.
- `reset` in 1: synchronous, active-low. Sampled on the `clk` rising edge.
- `start` in 1: request a multiply. Sampled only in IDLE.
- `mcand_in` in 32: multiplicand, latched on accepted `start`.
- `mplier_in` in 32: multiplier, latched on accepted `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse in the DONE state.
- `product` out 32: low 32 bits of the product. Held until the next accepted `start`.
- `alu_a` out 32: ALU operand a.
- `alu_b` out 32: ALU operand b.
- `alu_control` out 4: ALU control.
- `alu_result` in 32: ALU result, combinational from the driven operands.

## Operation
- Registers:
  - `acc` (32)
  - `mcand` (32)
  - `mplier` (32)
  - `count` (5)
  - `state` (2: IDLE, ADD, SHL, DONE)
- IDLE:
  - Outputs: `alu_a`=0, `alu_b`=0, `alu_control`=4'b0000.
  - On `start`=1: `acc`<=0, `mcand`<=`mcand_in`, `mplier`<=`mplier_in`, `count`<=0; go to ADD.
  - On `start`=0: stay in IDLE.
- ADD:
  - Outputs: `alu_a`=`acc`, `alu_b`=`mcand`, `alu_control`=4'b0010.
  - If `mplier`==0: go to DONE with no register update (early termination).
  - Otherwise: if `mplier[0]`, `acc`<=`alu_result`. Go to SHL.
- SHL:
  - Outputs: `alu_a`=`mcand`, `alu_b`=32'd1, `alu_control`=4'b0100.
  - Updates: `mcand`<=`alu_result`, `mplier`<=`mplier`>>1 (logical, internal), `count`<=`count`+1.
  - If `count`==31: go to DONE. Otherwise go to ADD.
- DONE:
  - `product`<=`acc`, `done`=1; go to IDLE unconditionally.
  - ALU outputs as in IDLE.
- Arithmetic:
  - All sums wrap modulo 2^32.
  - Bits shifted out of `mcand` are discarded.
  - No overflow indication.
- `start` in ADD, SHL or DONE is ignored. It is not queued.
- Operands are unsigned. The low-32 result equals the two's-complement signed low-32 result.

## Timing
- Reset (`reset`=0 at an edge):
  - `state`=IDLE; `acc`, `mcand`, `mplier`, `count`, `product` = 0.
  - `busy`=0, `done`=0; ALU outputs 0 / 4'b0000.
- Reset mid-operation aborts immediately. `done` does not pulse, and `product` reads 0 after reset.
- Latency is counted from the edge that samples `start` (edge 0):
  - Let k be the index of the highest set bit of `mplier_in`, with k = 31 at most.
  - ADD occupies cycle 2i+1 and SHL occupies cycle 2i+2 for i = 0..k.
  - If k < 31: the final ADD is cycle 2k+3 and `done` is high in cycle 2k+4.
  - If k = 31: DONE follows SHL directly, so `done` is high in cycle 65.
  - `mplier_in`=0: ADD in cycle 1, `done` in cycle 2.
- `product` updates on the edge leaving DONE. It is valid from the cycle after `done` until the next accepted `start`.
- `busy` drops in the cycle after DONE.
- A new `start` is accepted in that first IDLE cycle, so there is no dead cycle.
- `alu_*` outputs are combinational from `state` and registers. They are stable for the whole cycle.

## Test plan
- 6 × 7:
  - `done` is high in cycle 8.
  - `product` = 42 afterward.
  - Waveform: `alu_control` alternates 0010/0100 over cycles 1–6; cycle 7 is ADD with `mplier`=0.
- `mcand`=0x1234, `mplier`=0:
  - `done` is high in cycle 2.
  - `product` = 0; `busy` is high for exactly 2 cycles.
- 0xFFFFFFFF × 0xFFFFFFFF:
  - `done` is high in cycle 65.
  - `product` = 0x00000001 (wrap check).
- 3 × 0x80000000:
  - `done` is high in cycle 65.
  - `product` = 0x80000000.
  - Check that ADD in cycles 1–63 leaves `acc`=0.
- Pulse `start` again with new operands in cycles 3–5 of a 6 × 7 run:
  - The second `start` is ignored and the result is 42.
  - `start` in the cycle after `done` is accepted (5 × 5 → 25).
- Assert `reset`=0 during cycle 10 of a 0xFFFF × 0xFFFF run:
  - Next cycle: `busy`=0, `product`=0, no `done` pulse.
  - A subsequent 2 × 3 gives 6.
